// File: rtl/vector_cache_pkg.sv
// -----------------------------------------------------------------------------
// vector_cache_pkg
// Shared constants and payload types for the vector cache read data path.
// No ports: this is a package. It holds the default widths used by
// read_db_mc and the request/response payload records for the default widths.
// -----------------------------------------------------------------------------
package vector_cache_pkg;

    localparam int RW_DB_ENTRY_NUM = 32;
    localparam int DATA_WIDTH      = 1024;
    localparam int VC_TXNID_W      = 8;
    localparam int VC_ROB_ID_W     = 6;
    localparam int VC_SB_W         = 16;
    localparam int RW_DB_IDX_W     = $clog2(RW_DB_ENTRY_NUM);

    // Tagged read request into the read data buffer.
    typedef struct packed {
        logic [RW_DB_IDX_W-1:0] entry_id;
        logic [VC_TXNID_W-1:0]  txnid;
        logic [VC_ROB_ID_W-1:0] rob_entry_id;
        logic [VC_SB_W-1:0]     sideband;
    } rdb_req_pld_t;

    // Response towards the upstream path.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [VC_TXNID_W-1:0]  txnid;
        logic [VC_ROB_ID_W-1:0] rob_entry_id;
        logic [VC_SB_W-1:0]     sideband;
    } us_data_pld_t;

endpackage

// File: rtl/rdb_out_fifo.sv
// -----------------------------------------------------------------------------
// rdb_out_fifo
// Two-entry in-order FIFO used as the output skid buffer of read_db_mc.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push_i        write push_data_i into the tail
//   push_data_i   payload to store
//   pop_i         drop the head entry
//   vld_o         FIFO holds at least one entry
//   head_o        oldest stored payload
//   cnt_o         number of stored entries (0..2)
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module rdb_out_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] head_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) wptr_q <= ~wptr_q;
            if (pop_i)  rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Payload storage is not reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rptr_q];
    assign vld_o  = (cnt_q != 2'd0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/read_db_mc.sv
// -----------------------------------------------------------------------------
// read_db_mc
// Read data buffer between the data RAM and the upstream response path.
// RAM writes fill entries and mark them occupied; a tagged read request
// consumes an occupied entry and its data plus tags are returned on a
// valid/ready output backed by a 2-deep skid FIFO.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   wr_vld/wr_entry_id/wr_data  entry write (always accepted)
//   rd_req_vld/rd_req_rdy       read request handshake
//   rd_req_entry_id             entry to consume
//   rd_req_txnid/rob_entry_id/sideband  tags carried to the response
//   us_vld/us_rdy               response handshake
//   us_data/us_txnid/us_rob_entry_id/us_sideband  response payload
//   entry_valid                 per-entry occupancy bitmap
//   err_wr_overwrite            pulse: write hit an occupied/consumed entry
// -----------------------------------------------------------------------------
module read_db_mc #(
    parameter int  ENTRY_NUM  = vector_cache_pkg::RW_DB_ENTRY_NUM,
    parameter int  DATA_WIDTH = vector_cache_pkg::DATA_WIDTH,
    parameter int  TXNID_W    = vector_cache_pkg::VC_TXNID_W,
    parameter int  ROB_ID_W   = vector_cache_pkg::VC_ROB_ID_W,
    parameter int  SB_W       = vector_cache_pkg::VC_SB_W,
    localparam int IDX_W      = $clog2(ENTRY_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_vld,
    input  logic [IDX_W-1:0]      wr_entry_id,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req_vld,
    output logic                  rd_req_rdy,
    input  logic [IDX_W-1:0]      rd_req_entry_id,
    input  logic [TXNID_W-1:0]    rd_req_txnid,
    input  logic [ROB_ID_W-1:0]   rd_req_rob_entry_id,
    input  logic [SB_W-1:0]       rd_req_sideband,
    output logic                  us_vld,
    input  logic                  us_rdy,
    output logic [DATA_WIDTH-1:0] us_data,
    output logic [TXNID_W-1:0]    us_txnid,
    output logic [ROB_ID_W-1:0]   us_rob_entry_id,
    output logic [SB_W-1:0]       us_sideband,
    output logic [ENTRY_NUM-1:0]  entry_valid,
    output logic                  err_wr_overwrite
);

    localparam int TAG_W = TXNID_W + ROB_ID_W + SB_W;
    localparam int PLD_W = DATA_WIDTH + TAG_W;

    logic [DATA_WIDTH-1:0] mem_q [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]  entry_valid_q;
    logic [ENTRY_NUM-1:0]  entry_valid_d;
    logic                  err_q;
    logic                  err_d;

    // Read stage: one registered array read plus its tags.
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [TAG_W-1:0]      rd_tag_q;
    logic                  inflight_q;

    logic                  pop;
    logic                  accept;
    logic [2:0]            credit_used;
    logic                  fifo_vld;
    logic [1:0]            fifo_cnt;
    logic [PLD_W-1:0]      fifo_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [PLD_W-1:0]      out_pld;

    assign pop = us_vld & us_rdy;

    // Occupancy of the output path (FIFO + read stage) after this cycle's pop.
    // The pop term lets a draining cycle accept a new request immediately.
    assign credit_used = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_req_rdy  = !rst & entry_valid_q[rd_req_entry_id] & (credit_used < 3'd2);
    assign accept      = rd_req_vld & rd_req_rdy;

    // Write sets, accept clears; a simultaneous write wins.
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_valid
        assign entry_valid_d[gi] = (wr_vld && (wr_entry_id == IDX_W'(gi))) ||
                                   (entry_valid_q[gi] &&
                                    !(accept && (rd_req_entry_id == IDX_W'(gi))));
    end

    assign err_d = wr_vld & (entry_valid_q[wr_entry_id] |
                             (accept & (rd_req_entry_id == wr_entry_id)));

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid_q <= '0;
            err_q         <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            entry_valid_q <= entry_valid_d;
            err_q         <= err_d;
            inflight_q    <= accept;
        end
    end

    // Array and read stage carry no reset. Non-blocking update gives
    // read-first behaviour when a write and a read target the same entry.
    always_ff @(posedge clk) begin
        if (wr_vld) mem_q[wr_entry_id] <= wr_data;
        if (accept) begin
            rd_data_q <= mem_q[rd_req_entry_id];
            rd_tag_q  <= {rd_req_txnid, rd_req_rob_entry_id, rd_req_sideband};
        end
    end

    // With an empty FIFO the read stage is presented directly (1-cycle
    // latency); if it is not taken it moves into the FIFO unchanged, so the
    // visible head stays stable under backpressure.
    assign fifo_push = inflight_q & ~(~fifo_vld & pop);
    assign fifo_pop  = pop & fifo_vld;

    rdb_out_fifo #(
        .W (PLD_W)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({rd_data_q, rd_tag_q}),
        .pop_i       (fifo_pop),
        .vld_o       (fifo_vld),
        .head_o      (fifo_head),
        .cnt_o       (fifo_cnt)
    );

    assign out_pld = fifo_vld ? fifo_head : {rd_data_q, rd_tag_q};
    assign us_vld  = fifo_vld | inflight_q;
    assign {us_data, us_txnid, us_rob_entry_id, us_sideband} = out_pld;

    assign entry_valid      = entry_valid_q;
    assign err_wr_overwrite = err_q;

endmodule
